// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             set_flags;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, op, in1, in2, set_flags,
        input  out, flags, busy, done, illegal
    );

    modport slave (
        input  start, op, in1, in2, set_flags,
        output out, flags, busy, done, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: ALU with registered result and {N,Z,C,V} flags; define ALU_SEQ_MUL_EN to add an iterative MUL.
// Operands are latched on an accepted start and executed on the following edge.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    typedef enum logic [4:0] {
        ADD, ADC, SUB, SBC, NEG, LSL, ASR, LSR, ROR, OR, AND, BIC,
        XOR, NOT, SXB, SXH, ZXB, ZXH, IN1, IN2, MUL
    } op_e;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             pend, sf_q, undef, c_new, v_new, ovf, ci, fin, c, v;
    logic [4:0]       op_q;
    logic [SHW-1:0]   s;
    logic [15:0]      h;
    logic [WIDTH-1:0] a, b, x, y, rot, res, prod;
    logic [WIDTH:0]   sum, lsl, lsr, asr;

    assign c = bus.flags[1];
    assign v = bus.flags[0];

    // All add/subtract forms share one adder: x + y + ci, with y inverted for subtraction.
    always_comb begin
        s     = b[SHW-1:0];
        h     = 16'(b);
        x     = (op_q == NEG) ? '0 : a;
        y     = (op_q == ADD || op_q == ADC) ? b : (op_q == NEG) ? ~a : ~b;
        ci    = (op_q == ADC || op_q == SBC) ? c : (op_q != ADD);
        sum   = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        lsl   = {1'b0, a} << s;
        lsr   = {a, 1'b0} >> s;
        asr   = $signed({a, 1'b0}) >>> s;
        rot   = WIDTH'({a, a} >> (int'(s) % WIDTH));
        res   = '0;
        c_new = c;
        v_new = v;
        undef = 1'b0;
        case (op_q)
            ADD, ADC, SUB, SBC, NEG: begin
                {c_new, res} = sum;
                v_new = ovf;
            end
            LSL: {c_new, res} = {(s == '0) ? c : lsl[WIDTH], lsl[WIDTH-1:0]};
            ASR: {res, c_new} = {asr[WIDTH:1], (s == '0) ? c : asr[0]};
            LSR: {res, c_new} = {lsr[WIDTH:1], (s == '0) ? c : lsr[0]};
            ROR: {c_new, res} = {(s == '0) ? c : rot[WIDTH-1], rot};
            OR:  res = a | b;
            AND: res = a & b;
            BIC: res = a & ~b;
            XOR: res = a ^ b;
            NOT: res = ~a;
            SXB: res = WIDTH'($signed(b[7:0]));
            SXH: res = WIDTH'($signed(h));
            ZXB: res = WIDTH'(b[7:0]);
            ZXH: res = WIDTH'(h);
            IN1: res = a;
            IN2: res = b;
            default: undef = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend        <= 1'b0;
            sf_q        <= 1'b0;
            op_q        <= '0;
            a           <= '0;
            b           <= '0;
            bus.out     <= '0;
            bus.flags   <= '0;
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            bus.done    <= pend || fin;
            bus.illegal <= pend && undef;
            pend        <= 1'b0;
            if (pend || fin)
                bus.out <= pend ? res : prod;
            if (pend ? (sf_q && !undef) : (fin && sf_q))
                bus.flags <= pend ? {res[WIDTH-1], res == '0, c_new, v_new}
                                  : {prod[WIDTH-1], prod == '0, c, v};
            if (bus.start && !bus.busy) begin
                pend <= !(MUL_EN && bus.op == MUL);
                op_q <= bus.op;
                a    <= bus.in1;
                b    <= bus.in2;
                sf_q <= bus.set_flags;
            end
        end
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} st_e;
    st_e              st;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mc, mp, acc;

    // One partial product per cycle; busy drops with the last step, the result lands a cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            bus.busy <= 1'b0;
            cnt      <= '0;
            mc       <= '0;
            mp       <= '0;
            acc      <= '0;
        end else begin
            if (st == RUN) begin
                acc <= acc + (mp[0] ? mc : '0);
                mc  <= mc << 1;
                mp  <= mp >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    st       <= FIN;
                    bus.busy <= 1'b0;
                end
            end else if (st == FIN)
                st <= IDLE;
            if (bus.start && !bus.busy && bus.op == MUL) begin
                st       <= RUN;
                bus.busy <= 1'b1;
                cnt      <= '0;
                mc       <= bus.in1;
                mp       <= bus.in2;
                acc      <= '0;
            end
        end
    end

    assign fin  = st == FIN;
    assign prod = acc;
`else
    assign bus.busy = 1'b0;
    assign fin      = 1'b0;
    assign prod     = '0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
// Builds with or without ALU_SEQ_MUL_EN; the MUL scenarios follow the macro.
module tb_alu_seq;
    localparam int     W     = 32;
    localparam longint TWO32 = 64'sh1_0000_0000;
    localparam longint MAXS  = 64'sh7FFF_FFFF;
    localparam longint MINS  = -64'sh8000_0000;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    int          n_chk   = 0;
    int          n_err   = 0;
    logic [31:0] m_out   = '0;
    logic [3:0]  m_fl    = '0;
    bit          m_ill   = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Architectural model: mathematical results, flags derived from range checks.
    task automatic ref_op(input int op, input logic [31:0] a, input logic [31:0] b, input bit sf);
        longint ua, ub, sa, sb, t, st, bo;
        int s;
        bit c, v, def;
        logic [31:0] r;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        s = int'(b[4:0]); c = m_fl[1]; v = m_fl[0]; def = 1'b1; r = '0;
        case (op)
            0, 1: begin
                t = ua + ub + ((op == 1) ? longint'(c) : 0);
                st = sa + sb + ((op == 1) ? longint'(c) : 0);
                c = t >= TWO32; v = st > MAXS || st < MINS; r = t[31:0];
            end
            2, 3: begin
                bo = (op == 3 && !c) ? 1 : 0;
                t = ua - ub - bo; st = sa - sb - bo;
                c = t >= 0; v = st > MAXS || st < MINS; r = t[31:0];
            end
            4: begin t = -ua; st = -sa; c = ua == 0; v = st > MAXS || st < MINS; r = t[31:0]; end
            5: begin t = ua << s; r = t[31:0]; if (s != 0) c = t[32]; end
            6: begin st = sa >>> s; r = st[31:0]; if (s != 0) c = a[s-1]; end
            7: begin r = a >> s; if (s != 0) c = a[s-1]; end
            8: begin r = (a >> s) | (a << (32 - s)); if (s != 0) c = a[s-1]; end
            9:  r = a | b;
            10: r = a & b;
            11: r = a & ~b;
            12: r = a ^ b;
            13: r = ~a;
            14: begin st = longint'($signed(b[7:0])); r = st[31:0]; end
            15: begin st = longint'($signed(b[15:0])); r = st[31:0]; end
            16: r = {24'h0, b[7:0]};
            17: r = {16'h0, b[15:0]};
            18: r = a;
            19: r = b;
`ifdef ALU_SEQ_MUL_EN
            20: begin t = ua * ub; r = t[31:0]; end
`endif
            default: def = 1'b0;
        endcase
        m_out = r;
        if (sf && def) m_fl = {r[31], r == 0, c, v};
        m_ill = !def;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input bit sf);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 5'(op); bus.in1 = a; bus.in2 = b; bus.set_flags = sf;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ref_op(op, a, b, sf);
        chk($sformatf("op%0d done early", op), bus.done, 1'b0);
        @(posedge clk);
        #1;
        chk($sformatf("op%0d done", op), bus.done, 1'b1);
        chk($sformatf("op%0d illegal", op), bus.illegal, m_ill);
        chk($sformatf("op%0d out a=%0h b=%0h", op, a, b), bus.out, m_out);
        chk($sformatf("op%0d flags a=%0h b=%0h", op, a, b), bus.flags, m_fl);
        chk($sformatf("op%0d busy", op), bus.busy, 1'b0);
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int op, busy_n, done_n, done_at;
        bus.start = 1'b0; bus.op = '0; bus.in1 = '0; bus.in2 = '0; bus.set_flags = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("reset out", bus.out, 0);
        chk("reset flags", bus.flags, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset illegal", bus.illegal, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        issue(0, 32'h7FFF_FFFF, 32'h1, 1'b1);
        chk("add ovf out", bus.out, 32'h8000_0000);
        chk("add ovf flags", bus.flags, 4'b1001);
        issue(2, 32'd5, 32'd5, 1'b1);
        chk("sub out", bus.out, 0);
        chk("sub flags", bus.flags, 4'b0110);
        issue(3, 32'd0, 32'd0, 1'b1);
        chk("sbc out", bus.out, 0);
        chk("sbc flags", bus.flags, 4'b0110);
        issue(7, 32'h3, 32'd1, 1'b1);
        chk("lsr1 out", bus.out, 32'h1);
        chk("lsr1 C", bus.flags[1], 1'b1);
        issue(0, 32'd0, 32'd0, 1'b1);
        issue(7, 32'h3, 32'd0, 1'b1);
        chk("lsr0 out", bus.out, 32'h3);
        chk("lsr0 C", bus.flags[1], 1'b0);
        issue(25, 32'h1234, 32'h5678, 1'b1);
        chk("op25 illegal", bus.illegal, 1'b1);
        chk("op25 out", bus.out, 0);
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("preset CV flags", bus.flags, 4'b0111);
        issue(12, 32'h0, 32'h0, 1'b0);
        chk("no set_flags", bus.flags, 4'b0111);

`ifdef ALU_SEQ_MUL_EN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 5'd20; bus.in1 = 32'h1_0000; bus.in2 = 32'h1_0003; bus.set_flags = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ref_op(20, 32'h1_0000, 32'h1_0003, 1'b1);
        busy_n = 0; done_n = 0; done_at = -1;
        for (int j = 0; j <= 40; j++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = j;
                chk("mul busy in done cycle", bus.busy, 1'b0);
            end
            bus.start = (j == 5);
            if (j == 5) begin bus.op = 5'd0; bus.in1 = 32'h1; bus.in2 = 32'h1; end
            @(posedge clk);
            #1;
        end
        chk("mul busy cycles", busy_n, 32);
        chk("mul done edge", done_at, 33);
        chk("mul done count", done_n, 1);
        chk("mul out", bus.out, 32'h0003_0000);
        chk("mul out model", bus.out, m_out);
        chk("mul flags", bus.flags, 4'b0011);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 5'd20; bus.in1 = 32'd5; bus.in2 = 32'd7; bus.set_flags = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mul abort out", bus.out, 0);
        chk("mul abort flags", bus.flags, 0);
        chk("mul abort busy", bus.busy, 0);
        chk("mul abort done", bus.done, 0);
        m_out = '0; m_fl = '0;
        @(negedge clk) reset_n = 1'b1;
        done_n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_n++;
        end
        chk("no done after abort", done_n, 0);
`else
        issue(20, 32'h7, 32'h9, 1'b1);
        chk("op20 illegal", bus.illegal, 1'b1);
        chk("op20 out", bus.out, 0);
`endif

        issue(18, 32'hDEAD_BEEF, 32'h0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset out", bus.out, 0);
        chk("async reset flags", bus.flags, 0);
        m_out = '0; m_fl = '0;
        @(negedge clk) reset_n = 1'b1;
        issue(1, 32'hFFFF_FFFF, 32'h1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 19));
            issue(op, rnd(), rnd(), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
